inv_result_fifo: RTL

//  Downstream stage of the 32-bit inversion/transform block: captures its per-cycle result words

---
 rtl/inv_result_fifo_if.sv | 26 ++
 rtl/inv_result_fifo.sv | 94 +++++++++
 2 files changed

// File: rtl/inv_result_fifo_if.sv
// Handshake bundle between the transform stage, the result FIFO and its consumer.
// Both channels use valid/ready: a word moves on a rising edge where valid and ready
// are both high; valid holders keep data stable until accepted, and ready never
// depends combinationally on valid from the same side.
interface inv_result_fifo_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;

  // Drives words in and accepts words out (transform stage plus consumer).
  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data
  );

  // The FIFO itself.
  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data
  );
endinterface

// File: rtl/inv_result_fifo.sv
// First-word-fall-through result FIFO behind the 32-bit inversion/transform block.
// Keeps a running XOR checksum of every accepted word.
// Optional feature macro: INV_FIFO_OVERFLOW_EN -- when defined, a sticky overflow flag
// records any attempt to write while full; otherwise overflow is constant 0.
module inv_result_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  inv_result_fifo_if.slave           bus,
  output logic [$clog2(DEPTH):0]     count,
  output logic [WIDTH-1:0]           checksum,
  output logic                       overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

  // Storage is never reset; only bookkeeping state is.
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;

  logic full;
  logic empty;
  logic push;
  logic pop;

  // Flags depend only on count, so in_ready has no path from out_ready.
  assign full  = (count == FULL_COUNT);
  assign empty = (count == '0);

  assign bus.in_ready  = !full;
  assign bus.out_valid = !empty;
  // Head word straight from storage; stale when empty.
  assign bus.out_data  = mem[rd_ptr];

  assign push = bus.in_valid  && !full;
  assign pop  = bus.out_ready && !empty;

  // Capture accepted words; reset-cycle handshakes are discarded.
  always_ff @(posedge clk) begin
    if (push && !rst) begin
      mem[wr_ptr] <= bus.in_data;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Occupancy: simultaneous push and pop leave it unchanged.
  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (push && !pop) begin
      count <= count + 1'b1;
    end else if (pop && !push) begin
      count <= count - 1'b1;
    end
  end

  // Running XOR of accepted words; pops and dropped words do not touch it.
  always_ff @(posedge clk) begin
    if (rst) begin
      checksum <= '0;
    end else if (push) begin
      checksum <= checksum ^ bus.in_data;
    end
  end

`ifdef INV_FIFO_OVERFLOW_EN
  // Sticky record of a producer offering a word while the FIFO is full.
  always_ff @(posedge clk) begin
    if (rst) begin
      overflow <= 1'b0;
    end else if (bus.in_valid && full) begin
      overflow <= 1'b1;
    end
  end
`else
  assign overflow = 1'b0;
`endif

endmodule
